regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port register file for the MIPS datapath; the successor to the current two-port, 32×32 file. It adds configurable data width, depth and read-port count, a synchronous reset that sweeps every entry to a known value, and optional write-to-read bypass. It sits between decode (read addresses) and writeback (write port), with one cycle of read latency.

## Interface

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write is forwarded to a matching read; 0 = read returns the pre-write value
- SP_IDX, 29, index loaded with SP_INIT during the clear sweep
- SP_INIT, 51199, stack pointer reset value
- GP_IDX, 28, index loaded with GP_INIT during the clear sweep
- GP_INIT, 6300, global pointer reset value

Ports:
- clk, input, 1, the single clock; all state updates on its rising edge
- rst, input, 1, synchronous, active-high reset
- busy, output, 1, high while in reset or during the clear sweep
- we, input, 1, write enable
- waddr, input, ADDR_W, write address
- wdata, input, DATA_W, write data
- raddr, input, NUM_RD*ADDR_W, read addresses; port k is bits [k*ADDR_W +: ADDR_W]
- rdata, output, NUM_RD*DATA_W, registered read data; port k is bits [k*DATA_W +: DATA_W]

## Operation

- FSM has two states: CLEAR and READY.
  - rst high at any edge: go to CLEAR, set sweep pointer ptr=0, busy=1, all rdata=0.
  - CLEAR, rst low: each cycle write mem[ptr] and increment ptr.
    - Value written is SP_INIT when ptr==SP_IDX, GP_INIT when ptr==GP_IDX, else 0.
    - When ptr==DEPTH-1 is written, go to READY on the same edge.
  - READY: normal operation; busy=0.
- During CLEAR:
  - we is ignored; external writes are dropped, not queued.
  - rdata is held at 0.
- Write path (READY):
  - When we=1 and waddr!=0, mem[waddr] is updated at the edge.
  - Writes to address 0 are discarded, so mem[0] always reads 0.
- Read path (READY):
  - At each edge, for every port k, rdata[k] loads mem[raddr[k]].
  - Address 0 returns 0.
  - Bypass applies when BYPASS=1, we=1, waddr==raddr[k] and waddr!=0: rdata[k] loads wdata instead of the stored value. With BYPASS=0 the port loads the old value.
  - All ports are independent. Several ports may read the same address, and each port gets the same result.
- Widths: SP_INIT and GP_INIT are truncated or zero-extended to DATA_W. If SP_IDX or GP_IDX is at least DEPTH, that index is never hit and the corresponding load does not happen.

## Timing

- Read latency is 1 cycle: an address presented before edge N appears on rdata after edge N.
- Write latency:
  - A write at edge N is visible to an unbypassed read sampled at edge N+1.
  - With BYPASS=1 the write is also visible to a read sampled at edge N.
- Clear sweep:
  - rst deasserted before edge 0; DEPTH edges (0..DEPTH-1) perform the sweep.
  - busy falls after edge DEPTH-1.
  - The first accepted write or non-zero read is at edge DEPTH.
- Reset mid-sweep: ptr restarts at 0 and the full DEPTH-cycle sweep repeats. Partially cleared contents are irrelevant because every entry is rewritten.
- Reset in READY: contents are preserved until the sweep overwrites them. rdata is 0 from the reset edge onward.
- Simultaneous rst and we: rst wins and the write is dropped.
- Reset values: busy=1, rdata=0, ptr=0.

## Test plan

- Reset sweep, defaults:
  - Stimulus: rst for 2 cycles, then release; count cycles until busy=0.
  - Required: exactly 32 cycles; then raddr0=29, raddr1=28 gives rdata0=51199, rdata1=6300; every other address reads 0.
- Basic write/read:
  - Stimulus: write 0xDEADBEEF to r5, then read r5 on port 1 the next cycle.
  - Required: rdata1=0xDEADBEEF one cycle after the read address is presented.
- r0 protection:
  - Stimulus: write 0x12345678 to r0, then read r0 on both ports.
  - Required: both ports read 0.
- Bypass:
  - Stimulus: in the same cycle, we=1, waddr=7, wdata=0xA5A5A5A5, raddr0=7. Run once with BYPASS=1 and once with BYPASS=0, with r7 previously holding 0x11.
  - Required: BYPASS=1 gives rdata0=0xA5A5A5A5; BYPASS=0 gives rdata0=0x11, and the next read gives 0xA5A5A5A5.
- Writes and reset during the sweep:
  - Stimulus: assert we (r3 ← 0xFF) at sweep cycle 10, then rst at sweep cycle 20.
  - Required: busy stays 1 for 20+1+32 cycles from the first release; r3 reads 0 afterwards.
- Parametrisation:
  - Stimulus: DATA_W=16, ADDR_W=3, NUM_RD=3; perform three concurrent reads of distinct registers after writes.
  - Required: sweep takes 8 cycles; SP_IDX/GP_IDX ≥ 8 are never loaded; each port returns its own register's 16-bit value.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with reset clear sweep and optional write-to-read bypass
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int BYPASS  = 1,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 51199,
  parameter int GP_IDX  = 28,
  parameter int GP_INIT = 6300
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;
  // Out-of-range pointer indices are disabled rather than aliased onto a low entry
  localparam bit SP_ON = SP_IDX >= 0 && SP_IDX < DEPTH;
  localparam bit GP_ON = GP_IDX >= 0 && GP_IDX < DEPTH;
  localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] GP_A = ADDR_W'(GP_IDX);
  localparam logic [DATA_W-1:0] SP_V = DATA_W'($unsigned(SP_INIT));
  localparam logic [DATA_W-1:0] GP_V = DATA_W'($unsigned(GP_INIT));

  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] sweep_val;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    state <= rst ? CLEAR : state_nx;
    ptr   <= rst ? '0 : (state == CLEAR) ? ptr + 1'b1 : ptr;
  end

  always_comb begin
    state_nx  = (state == CLEAR && &ptr) ? READY : state;
    busy      = state == CLEAR;
    sweep_val = (SP_ON && ptr == SP_A) ? SP_V : (GP_ON && ptr == GP_A) ? GP_V : '0;
  end

  // Reset wins over both the sweep and external writes
  always_ff @(posedge clk)
    if (!rst) begin
      if (state == CLEAR) mem[ptr] <= sweep_val;
      else if (we && waddr != '0) mem[waddr] <= wdata;
    end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] q;
    assign a = raddr[k*ADDR_W +: ADDR_W];
    assign rdata[k*DATA_W +: DATA_W] = q;
    always_ff @(posedge clk)
      q <= (rst || busy || a == '0) ? '0 :
           (BYPASS != 0 && we && waddr == a) ? wdata : mem[a];
  end
endmodule
